// File: rtl/uart_data_loader.sv
// uart_data_loader: takes bytes from the UART RX decoder and writes them into
// the frame RAM at addresses 0..DEPTH-1. It signals fin once the whole frame
// is resident, or err if the RX line goes silent mid-frame.
module uart_data_loader #(
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 65536,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              fin,
  output logic              err,
  output logic              ovf,
  output logic [ADDR_W:0]   byte_cnt
);

  localparam int CW = ADDR_W + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST_C = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;     // byte count; low ADDR_W bits act as the write pointer
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                ram_wen_q, ram_wen_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                busy_q, busy_d;
  logic                fin_q, fin_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;

  // Next-state and registered-output logic for the load FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    ram_wen_d   = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    busy_d      = busy_q;
    fin_d       = fin_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          // Any rx_valid arriving with start is deliberately dropped.
          state_d = LOAD;
          cnt_d   = '0;
          tmo_d   = '0;
          busy_d  = 1'b1;
          fin_d   = 1'b0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
        end else if (state_q == DONE && rx_valid) begin
          ovf_d = 1'b1;
        end
      end
      LOAD: begin
        if (cnt_q == DEPTH_C) begin
          // The last write was issued on the previous edge. Close the frame
          // and keep ram_addr at DEPTH-1.
          state_d = DONE;
          busy_d  = 1'b0;
          fin_d   = 1'b1;
        end else if (rx_valid) begin
          ram_wen_d   = 1'b1;
          ram_addr_d  = cnt_q[ADDR_W-1:0];
          ram_wdata_d = rx_data;
          cnt_d       = cnt_q + CW'(1);
          tmo_d       = '0;
        end else if (tmo_q == TMO_LAST_C) begin
          // The counter reaches TIMEOUT on this edge, so abort the frame.
          tmo_d   = tmo_q + TW'(1);
          state_d = ERROR;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
      fin_q       <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
      fin_q       <= fin_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ram_wen   = ram_wen_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;
  assign fin       = fin_q;
  assign err       = err_q;
  assign ovf       = ovf_q;
  assign byte_cnt  = cnt_q;

endmodule

// File: tb/tb_uart_data_loader.sv
// Bench for uart_data_loader. A small instance (DEPTH=4, TIMEOUT=20) gets
// directed steps, and a default-parameter instance gets a full 64K frame.
module tb_uart_data_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        wen, busy, fin, err, ovf;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [16:0] bcnt;

  logic        start_b = 1'b0, rx_valid_b = 1'b0;
  logic [7:0]  rx_data_b = 8'h00;
  logic        b_wen, b_busy, b_fin, b_err, b_ovf;
  logic [15:0] b_addr;
  logic [7:0]  b_wdata;
  logic [16:0] b_bcnt;

  always #5 clk = ~clk;

  uart_data_loader #(.ADDR_W(16), .DEPTH(4), .DATA_W(8), .TIMEOUT(20)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .ram_wen(wen), .ram_addr(addr), .ram_wdata(wdata), .busy(busy), .fin(fin),
    .err(err), .ovf(ovf), .byte_cnt(bcnt));

  uart_data_loader u_big (
    .clk(clk), .rst_n(rst_n), .start(start_b), .rx_valid(rx_valid_b), .rx_data(rx_data_b),
    .ram_wen(b_wen), .ram_addr(b_addr), .ram_wdata(b_wdata), .busy(b_busy), .fin(b_fin),
    .err(b_err), .ovf(b_ovf), .byte_cnt(b_bcnt));

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  cyc = 0;
  int  exp_ptr = 0;
  int  n_tot = 0, n_fail = 0;
  int  b_wr = 0, b_bad = 0, b_exp = 0;
  logic [15:0] b_last = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every small-instance RAM write away from the active edge.
  always @(negedge clk) begin
    if (wen === 1'b1) obs_q.push_back('{cyc: cyc, addr: addr, data: wdata});
  end

  // Big instance: the stream is addr == i, data == i[7:0].
  always @(negedge clk) begin
    if (b_wen === 1'b1) begin
      if (b_addr !== 16'(b_exp) || b_wdata !== 8'(b_exp)) b_bad++;
      b_wr++;
      b_exp++;
      b_last = b_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    exp_q.push_back('{cyc: cyc + 1, addr: 16'(exp_ptr), data: b});
    exp_ptr++;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    wr_t e, o;
    check({tag, "_nwr"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_addr"}, o.addr, e.addr);
      check({tag, "_data"}, o.data, e.data);
      check({tag, "_cyc"}, o.cyc, e.cyc);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wen"}, wen, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_wdata"}, wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fin"}, fin, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_bcnt"}, bcnt, 0);
  endtask

  initial begin
    logic [7:0] pat [4];
    pat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    // Reset state.
    tick(3);
    check_zero("rst");
    rst_n = 1'b1;
    tick(1);

    // Spaced frame.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("s1_busy", busy, 1);
    exp_ptr = 0;
    for (int i = 0; i < 4; i++) begin
      tick(9);
      send(pat[i]);
    end
    check("s1_fin_early", fin, 0);
    tick(1);
    check("s1_fin", fin, 1);
    check("s1_bcnt", bcnt, 4);
    check("s1_busy_lo", busy, 0);
    check("s1_err", err, 0);
    tick(1);
    check("s1_addr_hold", addr, 3);
    drain("s1");

    // Back-to-back frame, starting from DONE.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    exp_ptr = 0;
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
    tick(1);
    check("s2_fin", fin, 1);
    check("s2_bcnt", bcnt, 4);
    drain("s2");

    // Byte while in DONE sets ovf and produces no write.
    rx_valid = 1'b1; rx_data = 8'h55;
    tick(1);
    rx_valid = 1'b0;
    tick(1);
    check("ovf_set", ovf, 1);
    check("ovf_fin", fin, 1);
    check("ovf_nowr", obs_q.size(), 0);

    // start together with rx_valid: the byte is dropped and flags clear.
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
    tick(1);
    start = 1'b0; rx_valid = 1'b0;
    check("rs_ovf", ovf, 0);
    check("rs_fin", fin, 0);
    check("rs_busy", busy, 1);
    check("rs_bcnt", bcnt, 0);
    tick(1);
    check("rs_drop", obs_q.size(), 0);
    exp_ptr = 0;
    send(8'h11);
    send(8'h22);
    tick(1);
    drain("rs");

    // start during LOAD is ignored and the pointer continues.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("ign_busy", busy, 1);
    check("ign_bcnt", bcnt, 2);
    send(8'h33);
    tick(1);
    drain("ign");

    // Async reset between edges, mid-frame.
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("arst");
    tick(2);
    check("arst_nowr", obs_q.size(), 0);
    rst_n = 1'b1;
    tick(1);

    // Timeout: two bytes, then silence.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    exp_ptr = 0;
    send(8'h61);
    send(8'h62);
    tick(19);
    check("to_early", err, 0);
    tick(1);
    check("to_err", err, 1);
    check("to_fin", fin, 0);
    check("to_busy", busy, 0);
    check("to_bcnt", bcnt, 2);
    drain("to");
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("to_clr", err, 0);
    check("to_rebusy", busy, 1);
    exp_ptr = 0;
    send(8'h77);
    tick(1);
    drain("to_re");

    // Full 64K frame on the default-parameter instance.
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      rx_valid_b = 1'b1;
      rx_data_b  = 8'(i);
      tick(1);
    end
    rx_valid_b = 1'b0;
    tick(2);
    check("big_bad", b_bad, 0);
    check("big_nwr", b_wr, 65536);
    check("big_last", b_last, 16'hFFFF);
    check("big_addr", b_addr, 16'hFFFF);
    check("big_bcnt", b_bcnt, 65536);
    check("big_fin", b_fin, 1);
    check("big_err", b_err, 0);

    $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
    $finish;
  end

endmodule

// File: doc/uart_data_loader.md
Name: uart_data_loader

Overview:
- UART-receive-side image loader: writes bytes arriving from the UART receiver into the frame RAM at sequential addresses 0..DEPTH-1.
- This is the write-side counterpart of the UART data-retrieval path, which reads the RAM out to the transmitter.
- Sits between the UART RX byte decoder and the RAM write port, and tells the downsampling core when a complete frame is resident.

Parameters:
- ADDR_W, 16, RAM address width.
- DEPTH, 65536, bytes per frame; must satisfy 2 <= DEPTH <= 2^ADDR_W.
- DATA_W, 8, byte width.
- TIMEOUT, 1000000, clk cycles of RX silence allowed mid-frame before abort; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level-sampled request to begin a frame load.
- rx_valid  in  1  one-cycle strobe from UART RX; byte present on rx_data.
- rx_data  in  DATA_W  received byte.
- ram_wen  out  1  RAM write enable, one cycle per byte.
- ram_addr  out  ADDR_W  RAM write address.
- ram_wdata  out  DATA_W  RAM write data.
- busy  out  1  high while in LOAD.
- fin  out  1  frame complete; held until next start.
- err  out  1  timeout abort; held until next start.
- ovf  out  1  sticky: byte received while in DONE.
- byte_cnt  out  ADDR_W+1  bytes written in current/last frame.

Behaviour:
- States: IDLE, LOAD, DONE, ERROR. All outputs registered.
- Reset (async, rst_n=0): state=IDLE; ram_wen=0, ram_addr=0, ram_wdata=0, busy=0, fin=0, err=0, ovf=0, byte_cnt=0; write pointer and timeout counter cleared. Takes effect immediately, including mid-frame. No further RAM writes after reset.
- Start handling (IDLE, DONE, ERROR):
  - start=1 -> LOAD next cycle.
  - Same edge: pointer=0, byte_cnt=0, timeout counter=0, fin=0, err=0, ovf=0, busy=1.
  - An rx_valid on the same edge as start is dropped.
- LOAD, accepted byte:
  - rx_valid at edge n -> at edge n+1: ram_wen=1, ram_addr=pointer, ram_wdata=rx_data sampled at n.
  - On that same edge: pointer+1, byte_cnt+1, timeout counter=0.
  - ram_wen returns to 0 on the following edge unless another rx_valid arrived. Back-to-back rx_valid on consecutive cycles produces consecutive writes.
- LOAD, final byte:
  - When the write issued has ram_addr=DEPTH-1: the next edge gives state=DONE, busy=0, fin=1, byte_cnt=DEPTH.
  - ram_addr holds DEPTH-1 (no wrap to 0).
- LOAD, timeout:
  - Timeout counter increments each cycle without rx_valid, including before the first byte.
  - Reaching TIMEOUT -> ERROR next edge: busy=0, err=1, fin=0.
  - byte_cnt keeps the partial count; RAM contents are left as written.
- start while in LOAD: ignored; no restart mid-frame.
- DONE: rx_valid -> no write, ovf=1 (sticky).
- IDLE / ERROR: rx_valid ignored, no flags change.
- Only one of fin/err is ever 1; busy=1 implies fin=err=0.
- Latency: byte strobe to RAM write = 1 cycle. Last strobe to fin = 2 cycles.

Test Plan:
- DEPTH=4, TIMEOUT=20: reset, pulse start, send bytes 0xA1,0xB2,0xC3,0xD4 at 10-cycle spacing -> four single-cycle ram_wen at addr 0..3 with matching data, each one cycle after its strobe; fin=1 two cycles after 0xD4 strobe; byte_cnt=4; busy=0.
- DEPTH=4: rx_valid on 4 consecutive cycles after start -> ram_wen high 4 consecutive cycles, addr 0,1,2,3; no drops; fin set.
- TIMEOUT=20: start, send 2 bytes, then silence -> err=1 exactly 20 cycles after last accepted strobe's counter reset; fin=0; byte_cnt=2; new start clears err and reloads from addr 0.
- After fin: send 0x55 -> no ram_wen, ovf=1. Then start and rx_valid on the same edge -> byte dropped, ovf/fin cleared, first write of next frame at addr 0.
- Mid-frame async reset: assert rst_n=0 between clock edges after 2 writes -> all outputs 0 immediately. start asserted during LOAD -> ignored, pointer continues.
- Default params: stream 65536 bytes with incrementing pattern -> last write at addr 0xFFFF, no wrap, byte_cnt=65536, fin=1.
